// File: rtl/char_motion_ctrl.sv
// Per-frame player sprite controller: position, facing, animation, shoot and hit/freeze sequencing.
// Optional macro CHAR_WRAP_EN makes walking past a screen edge wrap instead of clamp.
module char_motion_ctrl #(
    parameter int unsigned StartX      = 304,
    parameter int unsigned PosY        = 400,
    parameter int unsigned MinX        = 0,
    parameter int unsigned MaxX        = 608,
    parameter int unsigned Step        = 2,
    parameter int unsigned AnimDiv     = 4,
    parameter int unsigned ShootFrames = 8,
    parameter int unsigned HitFrames   = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start_of_frame_i,
    input  logic        left_key_i,
    input  logic        right_key_i,
    input  logic        fire_key_i,
    input  logic        hit_i,
    input  logic        resume_i,
    output logic [10:0] top_left_x_o,
    output logic [10:0] top_left_y_o,
    output logic [1:0]  frame_sel_o,
    output logic        facing_left_o,
    output logic        visible_o,
    output logic        shot_request_o,
    output logic        alive_o
);

    localparam int unsigned AnimW = $clog2(AnimDiv + 1);
    localparam int unsigned CntW  =
        $clog2(HitFrames > ShootFrames ? HitFrames : ShootFrames) + 1;
    localparam logic [10:0] XStart    = 11'(StartX);
    localparam logic [10:0] XMin      = 11'(MinX);
    localparam logic [10:0] XMax      = 11'(MaxX);
    localparam logic [10:0] XStep     = 11'(Step);
    localparam logic [10:0] XLeftThr  = 11'(MinX + Step);
    localparam logic [10:0] XRightThr = 11'(MaxX - Step);

    typedef enum logic [2:0] {StIdle, StWalk, StShoot, StHit, StFrozen} state_e;

    state_e            state_q, state_d;
    logic [10:0]       x_q, x_d;
    logic [1:0]        frame_sel_q, frame_sel_d;
    logic              facing_q, facing_d;
    logic              visible_q, visible_d;
    logic              shot_q, shot_d;
    logic              alive_q, alive_d;
    logic [AnimW-1:0]  anim_cnt_q, anim_cnt_d;
    logic              anim_phase_q, anim_phase_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              hit_pend_q, hit_pend_d;
    logic              resume_pend_q, resume_pend_d;
    logic              fire_prev_q, fire_prev_d;

    logic              hit_now, resume_now, fire_edge, accept_hit, enter_hit;
    logic [10:0]       x_left, x_right;

    assign accept_hit = (state_q != StHit) && (state_q != StFrozen);
    assign hit_now    = hit_pend_q | (hit_i & accept_hit);
    assign resume_now = resume_pend_q | (resume_i & (state_q == StFrozen));
    assign fire_edge  = fire_key_i & ~fire_prev_q;
    assign cnt_inc    = cnt_q + 1'b1;

`ifdef CHAR_WRAP_EN
    assign x_left  = (x_q < XLeftThr)  ? XMax : x_q - XStep;
    assign x_right = (x_q > XRightThr) ? XMin : x_q + XStep;
`else
    assign x_left  = (x_q < XLeftThr)  ? XMin : x_q - XStep;
    assign x_right = (x_q > XRightThr) ? XMax : x_q + XStep;
`endif

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        frame_sel_d   = frame_sel_q;
        facing_d      = facing_q;
        visible_d     = visible_q;
        shot_d        = 1'b0;
        alive_d       = alive_q;
        anim_cnt_d    = anim_cnt_q;
        anim_phase_d  = anim_phase_q;
        cnt_d         = cnt_q;
        fire_prev_d   = fire_prev_q;
        enter_hit     = 1'b0;
        hit_pend_d    = hit_pend_q | (hit_i & accept_hit);
        resume_pend_d = resume_pend_q | (resume_i & (state_q == StFrozen));

        if (start_of_frame_i) begin
            hit_pend_d    = 1'b0;
            resume_pend_d = 1'b0;
            fire_prev_d   = fire_key_i;
            case (state_q)
                StIdle, StWalk: begin
                    if (hit_now) begin
                        enter_hit = 1'b1;
                    end else if (fire_edge) begin
                        state_d      = StShoot;
                        frame_sel_d  = 2'd3;
                        cnt_d        = '0;
                        shot_d       = 1'b1;
                        anim_cnt_d   = '0;
                        anim_phase_d = 1'b0;
                    end else if (left_key_i ^ right_key_i) begin
                        state_d     = StWalk;
                        x_d         = left_key_i ? x_left : x_right;
                        facing_d    = left_key_i;
                        frame_sel_d = anim_phase_q ? 2'd2 : 2'd1;
                        if (anim_cnt_q == AnimW'(AnimDiv - 1)) begin
                            anim_cnt_d   = '0;
                            anim_phase_d = ~anim_phase_q;
                        end else begin
                            anim_cnt_d = anim_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d      = StIdle;
                        frame_sel_d  = 2'd0;
                        anim_cnt_d   = '0;
                        anim_phase_d = 1'b0;
                    end
                end
                StShoot: begin
                    if (hit_now) begin
                        enter_hit = 1'b1;
                    end else if (cnt_q == CntW'(ShootFrames - 1)) begin
                        state_d     = StIdle;
                        frame_sel_d = 2'd0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StHit: begin
                    if (cnt_q == CntW'(HitFrames - 1)) begin
                        state_d   = StFrozen;
                        visible_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d     = cnt_inc;
                        // Blink phase flips every 8 frames, starting hidden.
                        visible_d = cnt_inc[3];
                    end
                end
                StFrozen: begin
                    if (resume_now) begin
                        state_d     = StIdle;
                        x_d         = XStart;
                        facing_d    = 1'b0;
                        alive_d     = 1'b1;
                        visible_d   = 1'b1;
                        frame_sel_d = 2'd0;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (enter_hit) begin
                state_d      = StHit;
                alive_d      = 1'b0;
                visible_d    = 1'b0;
                frame_sel_d  = 2'd0;
                cnt_d        = '0;
                anim_cnt_d   = '0;
                anim_phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StIdle;
            x_q           <= XStart;
            frame_sel_q   <= 2'd0;
            facing_q      <= 1'b0;
            visible_q     <= 1'b1;
            shot_q        <= 1'b0;
            alive_q       <= 1'b1;
            anim_cnt_q    <= '0;
            anim_phase_q  <= 1'b0;
            cnt_q         <= '0;
            hit_pend_q    <= 1'b0;
            resume_pend_q <= 1'b0;
            fire_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            frame_sel_q   <= frame_sel_d;
            facing_q      <= facing_d;
            visible_q     <= visible_d;
            shot_q        <= shot_d;
            alive_q       <= alive_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_phase_q  <= anim_phase_d;
            cnt_q         <= cnt_d;
            hit_pend_q    <= hit_pend_d;
            resume_pend_q <= resume_pend_d;
            fire_prev_q   <= fire_prev_d;
        end
    end

    assign top_left_x_o   = x_q;
    assign top_left_y_o   = 11'(PosY);
    assign frame_sel_o    = frame_sel_q;
    assign facing_left_o  = facing_q;
    assign visible_o      = visible_q;
    assign shot_request_o = shot_q;
    assign alive_o        = alive_q;

endmodule

// File: doc/char_motion_ctrl.md
Name: char_motion_ctrl

Overview:
- Per-frame controller for the player character sprite.
- Samples keyboard inputs once per video frame and owns the character's top-left position, facing direction and animation frame index.
- Handles shoot and hit/blink/frozen sequencing.
- Feeds the square-object locator and the character bitmap ROM: topLeftX/Y drive the rectangle, and frameSel/facingLeft drive the bitmap address.

Parameters:
START_X, 304, X position after reset and after resume
POS_Y, 400, fixed Y position of character
MIN_X, 0, leftmost allowed topLeftX
MAX_X, 608, rightmost allowed topLeftX (640 minus 32-pixel width)
STEP, 2, pixels moved per frame while walking
ANIM_DIV, 4, frames per walk animation phase
SHOOT_FRAMES, 8, frames spent in SHOOT pose
HIT_FRAMES, 64, frames of hit blinking before freeze

Ports:
clk  in  1  system clock
resetN  in  1  async active-low reset
startOfFrame  in  1  one-cycle pulse per VGA frame
leftKey  in  1  level, move left requested
rightKey  in  1  level, move right requested
fireKey  in  1  level, fire requested
hit  in  1  one-cycle collision pulse, any cycle
resume  in  1  one-cycle pulse, leave FROZEN
topLeftX  out  11  character X position
topLeftY  out  11  character Y position, constant POS_Y
frameSel  out  2  bitmap frame: 0 stand, 1/2 walk, 3 shoot
facingLeft  out  1  1 = mirror bitmap horizontally
visible  out  1  gate for the drawing request
shotRequest  out  1  one-cycle pulse to the shot generator
alive  out  1  0 while in HIT or FROZEN

Behaviour:
- Interface: reset resetN, asynchronous, active-low; clock clk.
- Reset values: topLeftX=START_X, frameSel=0, facingLeft=0, visible=1, shotRequest=0, alive=1, state=IDLE, all counters=0, hitPending=0, firePrev=0.
- topLeftY is a constant POS_Y and is not registered.
- Hit latching: a hit pulse sets hitPending in any cycle.
  - hitPending clears at the next startOfFrame that consumes it.
  - Hits arriving while in HIT or FROZEN are discarded.
- Input timing: all state and position updates occur only on a startOfFrame cycle, with outputs registered on that edge (1-cycle latency). Keys are sampled on that same cycle.
- Fire edge detection: fireEdge = fireKey & ~firePrev. firePrev updates on every startOfFrame, so a held key does not autofire.
- Priority on each startOfFrame: hitPending > fireEdge > walk keys.
- IDLE:
  - hit -> HIT.
  - fireEdge -> SHOOT, with shotRequest=1 for exactly the next cycle.
  - Exactly one of leftKey/rightKey -> WALK.
  - Both or neither held -> stay IDLE, frameSel=0.
- WALK:
  - Each frame, move by STEP toward the key and set facingLeft=1 for left, 0 for right.
  - Clamp: left move with topLeftX < MIN_X+STEP gives MIN_X; right move with topLeftX > MAX_X-STEP gives MAX_X.
  - Animation counter increments each frame; frameSel toggles 1<->2 every ANIM_DIV frames.
  - No key or both keys -> IDLE, animation counter cleared.
  - hit and fire transitions are the same as from IDLE.
- SHOOT:
  - frameSel=3, no movement.
  - Frame counter counts SHOOT_FRAMES, then -> IDLE.
  - hit aborts to HIT.
  - Further fire edges are ignored.
- HIT:
  - alive=0, no movement, frameSel=0.
  - visible toggles every 8 frames, starting with 0 on entry.
  - After HIT_FRAMES frames -> FROZEN.
- FROZEN:
  - visible=1, alive=0.
  - A resume pulse (any cycle, latched like hit) moves to IDLE at the next startOfFrame, with topLeftX=START_X, facingLeft=0 and alive=1.
- Simultaneous events: a frame with both hit and fire edge goes to HIT and shotRequest stays 0.
- Mid-operation reset: resetN low in any state immediately restores all reset values.

Optional Feature:
- Macro: CHAR_WRAP_EN.
- When defined:
  - Walking past an edge wraps: a left move from topLeftX < MIN_X+STEP gives MAX_X; a right move from topLeftX > MAX_X-STEP gives MIN_X.
  - facingLeft is unchanged by the wrap.
- When undefined: clamp behaviour as specified in Behaviour.

Test Plan:
- Reset, then rightKey held for 10 frames -> topLeftX=324, facingLeft=0, frameSel sequence 1,1,1,1,2,2,2,2,1,1.
- Start at X=2, leftKey held 3 frames -> X=0,0,0 (clamped); with CHAR_WRAP_EN -> X=0, then 608, then 606.
- fireKey held 20 frames from IDLE -> exactly one shotRequest pulse, 1 cycle after the first startOfFrame; frameSel=3 for 8 frames, then 0.
- hit pulse mid-frame while walking -> at next startOfFrame alive=0 and visible=0; visible toggles every 8 frames; after 64 frames FROZEN with visible=1; a second hit during HIT is ignored.
- resume in FROZEN -> at next startOfFrame IDLE, topLeftX=304, alive=1.
- hit and fireKey rising on the same frame -> HIT entered, shotRequest never asserted; resetN pulsed during SHOOT -> all outputs at reset values immediately.
